pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Drives the enable/flush inputs of the
//   PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use hazards, taken branches and
//   data-memory wait handshakes. Adds a bounded memory-wait timeout with a sticky error state.
// PARAMETERS
//   MEM_TIMEOUT  15  max wait cycles in MEM_WAIT before ERR (1..2**TO_W-1)
//   TO_W          4  timeout counter width
// PORTS
//   clk              in   1   clock; all state updates on posedge clk
//   rst              in   1   reset, synchronous, active-low
//   id_rs            in   5   rs of instruction in ID
//   id_rt            in   5   rt of instruction in ID
//   ex_mem_read      in   1   instruction in EX is a load (ID/EX M-field MemRead)
//   ex_rt            in   5   destination reg of EX load
//   ex_branch_taken  in   1   branch resolved taken in EX
//   mem_access       in   1   MEM-stage instr reads or writes dmem (EX/MEM M-field rd|wr)
//   dmem_ready       in   1   dmem completes access this cycle
//   dmem_req         out  1   access request to dmem
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   out 1 each  register load enables
//   ifid_flush, idex_flush, exmem_flush           out 1 each  zero the register's controls (bubble)
//   timeout_err      out  1   sticky: memory timeout occurred
//   ctrl_state       out  2   current FSM state (debug)
//   stall_cnt, flush_cnt, wait_cnt                out 32 each performance counters
// BEHAVIOUR
//   FSM states: RUN=0, MEM_WAIT=1, ERR=2 (3 unused -> RUN). Outputs combinational from state+inputs.
//   Reset (rst==0 at posedge): state=RUN, timeout cnt=0, timeout_err=0, perf counters=0.
//     While in reset, enables=1, flushes=0, dmem_req=0.
//   RUN, priority high->low:
//     1 mem_access && !dmem_ready: all five enables=0, flushes=0, dmem_req=1; next MEM_WAIT, cnt=1.
//     2 ex_branch_taken: all enables=1, ifid_flush=1, idex_flush=1 (one cycle, two bubbles).
//     3 load-use: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt):
//       pc_en=0, ifid_en=0, idex_flush=1, others enabled; single-cycle stall, bubble cleared next cycle.
//     else all enables=1, flushes=0. dmem_req = mem_access.
//   Rule 2 wins over 3 in the same cycle (loaded instr in ID is wrong-path, flushed anyway).
//   MEM_WAIT: dmem_req=1. dmem_ready=0: all enables=0, cnt++; cnt==MEM_TIMEOUT -> ERR.
//     dmem_ready=1: release cycle, RUN rules 2/3 evaluated on held inputs; next RUN, cnt=0.
//     Ready on the same cycle cnt reaches MEM_TIMEOUT: ready wins -> RUN.
//   ERR: all enables=0, flushes=0, dmem_req=0, timeout_err=1; leaves only via reset.
//   exmem_flush asserted only in reset-free ERR entry cycle? No: exmem_flush is always 0 except
//     on the MEM_WAIT->ERR transition cycle (drops the faulting access); never elsewhere.
//   Reset mid-MEM_WAIT: next state RUN, cnt=0, dmem_req deasserted same cycle as rst==0.
// CONFIGURATION
//   PIPE_PERF_CNT_EN defined: stall_cnt += 1 per cycle pc_en==0 (excl. ERR); flush_cnt += 1 per
//     cycle ifid_flush||idex_flush; wait_cnt += 1 per MEM_WAIT cycle; saturate at 32'hFFFFFFFF.
//   Undefined: counters not built, stall_cnt/flush_cnt/wait_cnt tied to 0.
// STRUCTURE
//   pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/ERR), REG_ZERO=5'd0, REG_W=5.
//   One sub-module: load_use_detect (combinational compare of id_rs/id_rt vs ex_rt, rule 3 output).
// TESTING
//   1 ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; then all enabled.
//   2 ex_rt=0 with id_rs=0, ex_mem_read=1 -> no stall.
//   3 ex_branch_taken=1 with load-use active -> ifid_flush=idex_flush=1, pc_en=1.
//   4 mem_access=1, dmem_ready low 3 cycles then high -> 3 frozen cycles, release, wait_cnt=3 (w/ macro).
//   5 dmem_ready never high, MEM_TIMEOUT=15 -> ERR after 15 wait cycles, exmem_flush pulse, timeout_err=1 sticky.
//   6 rst=0 during MEM_WAIT -> RUN next cycle, dmem_req=0, timeout_err=0, counters=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register-file constants for the pipeline controller
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             hazard
);
   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign hazard = ex_mem_read && ex_rt != REG_ZERO && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer with dmem wait timeout; PIPE_PERF_CNT_EN builds perf counters
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             timeout_err,
   output logic [1:0]       ctrl_state,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt,
   output logic [31:0]      wait_cnt
);
   state_t state, nxt;
   logic [TO_W-1:0] cnt, cnt_nxt;
   logic lu, rules, freeze;
   load_use_detect u_lud (
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .hazard      (lu)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end
   // rules: branch/load-use logic is live this cycle; freeze: every register holds
   always_comb begin
      nxt         = RUN;
      cnt_nxt     = '0;
      rules       = 1'b0;
      freeze      = 1'b0;
      dmem_req    = 1'b0;
      exmem_flush = 1'b0;
      case (state)
         RUN: begin
            dmem_req = mem_access;
            freeze   = mem_access && !dmem_ready;
            rules    = !freeze;
            nxt      = freeze ? MEM_WAIT : RUN;
            cnt_nxt  = freeze ? TO_W'(1) : '0;
         end
         MEM_WAIT: begin
            dmem_req    = 1'b1;
            freeze      = !dmem_ready;
            rules       = dmem_ready;
            exmem_flush = freeze && cnt == TO_W'(MEM_TIMEOUT);
            nxt         = dmem_ready ? RUN : exmem_flush ? ERR : MEM_WAIT;
            cnt_nxt     = freeze && !exmem_flush ? cnt + 1'b1 : '0;
         end
         ERR: begin
            freeze = 1'b1;
            nxt    = ERR;
         end
         default: ;
      endcase
      if (!rst) begin
         freeze      = 1'b0;
         rules       = 1'b0;
         dmem_req    = 1'b0;
         exmem_flush = 1'b0;
      end
      // a taken branch flushes the load-dependent instr in ID, so it suppresses the stall
      ifid_flush = rules && ex_branch_taken;
      idex_flush = rules && (ex_branch_taken || lu);
      pc_en      = !freeze && !(rules && lu && !ex_branch_taken);
      ifid_en    = pc_en;
      idex_en    = !freeze;
      exmem_en   = !freeze;
      memwb_en   = !freeze;
   end
   assign timeout_err = state == ERR;
   assign ctrl_state  = state;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] s_q, f_q, w_q;
   always_ff @(posedge clk) begin
      if (!rst) begin
         s_q <= '0;
         f_q <= '0;
         w_q <= '0;
      end else begin
         if (!pc_en && state != ERR && s_q != '1) s_q <= s_q + 32'd1;
         if ((ifid_flush || idex_flush) && f_q != '1) f_q <= f_q + 32'd1;
         if (state == MEM_WAIT && w_q != '1) w_q <= w_q + 32'd1;
      end
   end
   assign stall_cnt = s_q;
   assign flush_cnt = f_q;
   assign wait_cnt  = w_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of stall/flush/wait/timeout behaviour of pipeline_ctrl
module tb_pipeline_ctrl;
   logic clk, rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
   logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, timeout_err;
   logic [1:0] ctrl_state;
   logic [31:0] stall_cnt, flush_cnt, wait_cnt;
   logic [8:0] ov;
   int ntests = 0, nfail = 0;
   // {pc,ifid,idex,exmem,memwb enables, ifid/idex/exmem flush, dmem_req}
   localparam logic [8:0] ALL_EN  = 9'b11111_000_0;
   localparam logic [8:0] LU      = 9'b00111_010_0;
   localparam logic [8:0] BR      = 9'b11111_110_0;
   localparam logic [8:0] BR_REQ  = 9'b11111_110_1;
   localparam logic [8:0] FRZ_REQ = 9'b00000_000_1;
   localparam logic [8:0] RUN_REQ = 9'b11111_000_1;
   localparam logic [8:0] ERR_IN  = 9'b00000_001_1;
   localparam logic [8:0] ERR_OUT = 9'b00000_000_0;
   pipeline_ctrl dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
      .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .timeout_err(timeout_err),
      .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
   );
   assign ov = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, dmem_req};
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] pc(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_perf(input string tag, input logic [31:0] s, input logic [31:0] f, input logic [31:0] w);
      chk({tag, "_stall"}, stall_cnt, pc(s));
      chk({tag, "_flush"}, flush_cnt, pc(f));
      chk({tag, "_wait"}, wait_cnt, pc(w));
   endtask
   initial begin
      rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b1; dmem_ready = 1'b0;
      #1;
      chk("rst_outs", 32'(ov), 32'(ALL_EN));
      tick(); tick();
      chk("rst_outs2", 32'(ov), 32'(ALL_EN));
      chk("rst_state", 32'(ctrl_state), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      chk_perf("rst", 0, 0, 0);
      rst = 1'b1; mem_access = 1'b0;
      // load-use on rs, then on rt
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
      #1; chk("lu_rs", 32'(ov), 32'(LU));
      tick();
      ex_mem_read = 1'b0; id_rs = 5'd1;
      #1; chk("lu_clear", 32'(ov), 32'(ALL_EN));
      tick();
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd2; id_rt = 5'd9;
      #1; chk("lu_rt", 32'(ov), 32'(LU));
      tick();
      // r0 destination never stalls
      ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      #1; chk("lu_r0", 32'(ov), 32'(ALL_EN));
      tick();
      // branch beats load-use
      ex_branch_taken = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1; chk("br_lu", 32'(ov), 32'(BR));
      tick();
      ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
      #1; chk("br_clear", 32'(ov), 32'(ALL_EN));
      chk_perf("t3", 2, 3, 0);
      // three frozen cycles then a release carrying a branch
      mem_access = 1'b1; dmem_ready = 1'b0;
      #1; chk("mw_entry", 32'(ov), 32'(FRZ_REQ));
      tick();
      chk("mw_state", 32'(ctrl_state), 32'd1);
      chk("mw_frz1", 32'(ov), 32'(FRZ_REQ));
      tick();
      chk("mw_frz2", 32'(ov), 32'(FRZ_REQ));
      tick();
      dmem_ready = 1'b1; ex_branch_taken = 1'b1;
      #1; chk("mw_release", 32'(ov), 32'(BR_REQ));
      tick();
      ex_branch_taken = 1'b0; mem_access = 1'b0;
      #1; chk("mw_back_run", 32'(ctrl_state), 32'd0);
      chk("mw_after", 32'(ov), 32'(ALL_EN));
      chk_perf("t4", 5, 4, 3);
      // timeout: 15 MEM_WAIT cycles, exmem_flush on the last
      mem_access = 1'b1; dmem_ready = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) begin
         chk("to_wait", 32'({ctrl_state, timeout_err, ov}), 32'({2'd1, 1'b0, FRZ_REQ}));
         tick();
      end
      chk("to_entry", 32'(ov), 32'(ERR_IN));
      chk("to_entry_st", 32'(ctrl_state), 32'd1);
      tick();
      chk("err_state", 32'(ctrl_state), 32'd2);
      chk("err_outs", 32'(ov), 32'(ERR_OUT));
      chk("err_flag", 32'(timeout_err), 32'd1);
      dmem_ready = 1'b1; mem_access = 1'b0; ex_branch_taken = 1'b1;
      tick(); tick();
      chk("err_sticky", 32'({ctrl_state, timeout_err, ov}), 32'({2'd2, 1'b1, ERR_OUT}));
      chk_perf("t5", 21, 4, 18);
      ex_branch_taken = 1'b0;
      rst = 1'b0; mem_access = 1'b1;
      #1; chk("err_rst_outs", 32'(ov), 32'(ALL_EN));
      tick();
      rst = 1'b1; mem_access = 1'b0;
      #1; chk("err_rst_st", 32'({ctrl_state, timeout_err}), 32'({2'd0, 1'b0}));
      chk_perf("err_rst", 0, 0, 0);
      // reset while waiting
      mem_access = 1'b1; dmem_ready = 1'b0;
      tick(); tick();
      chk("rmw_state", 32'(ctrl_state), 32'd1);
      rst = 1'b0;
      #1; chk("rmw_req", 32'(dmem_req), 32'd0);
      tick();
      rst = 1'b1; mem_access = 1'b0;
      #1; chk("rmw_run", 32'({ctrl_state, timeout_err, ov}), 32'({2'd0, 1'b0, ALL_EN}));
      chk_perf("rmw", 0, 0, 0);
      // ready arriving on the timeout cycle wins
      mem_access = 1'b1; dmem_ready = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) tick();
      dmem_ready = 1'b1;
      #1; chk("edge_release", 32'(ov), 32'(RUN_REQ));
      tick();
      mem_access = 1'b0;
      #1; chk("edge_run", 32'({ctrl_state, timeout_err}), 32'({2'd0, 1'b0}));
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
